// File: rtl/mem_access_ctrl.sv
// MEM stage access controller: steers EX/MEM requests to the dcache, stalls the
// pipeline on misses, registers the writeback result and sequences halt/flush.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_in,
  input  logic        regWr_in,
  input  logic        memToReg_in,
  input  logic [4:0]  regDst_in,
  input  logic        halt_in,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  input  logic        flushed,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        dcache_flush,
  output logic        mem_stall,
  output logic        wb_regWr,
  output logic [4:0]  wb_regDst,
  output logic [31:0] wb_data,
  output logic        halt_out,
  output logic        access_err,
  output logic [15:0] ld_count,
  output logic [15:0] st_count,
  output logic [31:0] stall_count,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WAIT   = 2'd1;
  localparam logic [1:0] FLUSH  = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic       mem_op;
  logic       is_load;
  logic       is_store;
  logic       in_access;
  logic       completing;
  logic       ld_done;
  logic       st_done;

  // Request handshake: dmemREN/dmemWEN stay asserted with stable address/data
  // for as long as EX/MEM holds the op; the cycle dhit is seen completes it.
  assign mem_op    = dREN_in | dWEN_in;
  assign is_store  = dWEN_in;
  assign is_load   = dREN_in & ~dWEN_in;
  assign in_access = (state == IDLE) || (state == WAIT);

  assign completing = in_access & ~(mem_op & ~dhit);
  assign ld_done    = completing & is_load;
  assign st_done    = completing & is_store;

  assign dmemaddr  = addr_in;
  assign dmemstore = store_in;
  assign dbg_state = state;

  always_comb begin
    dmemREN      = 1'b0;
    dmemWEN      = 1'b0;
    dcache_flush = 1'b0;
    mem_stall    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE, WAIT: begin
          dmemREN   = is_load;
          dmemWEN   = is_store;
          mem_stall = mem_op & ~dhit;
        end
        FLUSH: begin
          dcache_flush = 1'b1;
          mem_stall    = 1'b1;
        end
        HALTED: begin
          mem_stall = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A halt only starts the flush once no access is pending in the same cycle.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, WAIT: begin
        if (mem_op && !dhit)
          state_nx = WAIT;
        else if (!mem_op && halt_in)
          state_nx = FLUSH;
        else
          state_nx = IDLE;
      end
      FLUSH: begin
        if (flushed)
          state_nx = HALTED;
      end
      HALTED: state_nx = HALTED;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wb_regWr    <= 1'b0;
      wb_regDst   <= 5'd0;
      wb_data     <= 32'd0;
      halt_out    <= 1'b0;
      access_err  <= 1'b0;
      ld_count    <= 16'd0;
      st_count    <= 16'd0;
      stall_count <= 32'd0;
    end else begin
      state <= state_nx;

      if (mem_stall) begin
        wb_regWr    <= 1'b0;
        stall_count <= stall_count + 32'd1;
      end else if (completing) begin
        wb_regWr  <= regWr_in;
        wb_regDst <= regDst_in;
        wb_data   <= memToReg_in ? dmemload : addr_in;
      end

      if (ld_done && (ld_count != 16'hFFFF))
        ld_count <= ld_count + 16'd1;
      if (st_done && (st_count != 16'hFFFF))
        st_count <= st_count + 16'd1;

      if (in_access && dREN_in && dWEN_in)
        access_err <= 1'b1;

      if ((state == FLUSH) && flushed)
        halt_out <= 1'b1;
    end
  end

endmodule
